mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the multi-cycle CPU and a DMA/debug master.
//  Sits between the CPU controller's memory strobes (MemRead/MemWrite, IorD address) and the memory.
//  Arbitrates, sequences a fixed-latency access, returns read data and a one-cycle ack.
//  Drives cpu_stall so the CPU control FSM holds its state while it waits.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  1   memory read latency: cycles from mem_en to valid mem_rdata; legal 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset; asynchronous, active-high
//  cpu_req    in   1   CPU access request; held until cpu_ack
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_ack    out  1   1-cycle pulse: CPU access complete
//  cpu_rdata  out  DW  read data; valid with cpu_ack, held until next CPU read ack
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational)
//  dma_req / dma_we / dma_addr / dma_wdata / dma_ack / dma_rdata  same as cpu_* for the DMA port
//  mem_en     out  1   memory strobe, exactly 1 cycle per access
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_addr   out  AW  latched address of the granted requester
//  mem_wdata  out  DW  latched write data
//  mem_rdata  in   DW  memory read data
//  busy       out  1   state != IDLE
//  grant_id   out  1   0=CPU, 1=DMA; owner of the access in flight
// BEHAVIOUR
//  FSM: IDLE(00) ACCESS(01) WAIT(10) DONE(11). rst -> IDLE.
//  IDLE: if any req, pick a winner; latch its we/addr/wdata into mem_*; set grant_id; go to ACCESS.
//  ACCESS: mem_en=1 for one cycle; load cnt=MEM_LAT-1; MEM_LAT==1 -> DONE, otherwise -> WAIT.
//  WAIT: decrement cnt; on cnt==1 -> DONE.
//  DONE: winner's ack=1. On a read, capture mem_rdata into that port's rdata. -> IDLE.
//  Latency: req sampled in IDLE (cycle 0) -> ack in cycle MEM_LAT+1. Writes use the same timing.
//  The requester holds req and its fields stable until ack, and drops req on the ack edge.
//  No back-to-back accesses: at least one IDLE cycle between accesses.
//  Requests from the losing port stay pending, with no timeout; the losing port's stall stays high.
//  Requests arriving while busy are not sampled until IDLE.
//  Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, acks=0, rdata=0,
//    grant_id=0, last_grant=1, cnt=0.
//  Reset mid-access: abort immediately; no ack issued; requesters must re-request.
//  cnt is 4 bits wide. MEM_LAT outside 1..15 is a configuration error (elaboration-time check).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. On a tie, grant the port != last_grant; last_grant is updated in ACCESS.
//    last_grant resets to 1, so the CPU wins the first tie.
//  ARB_RR_EN undefined: fixed priority, CPU always wins ties; last_grant is still maintained but unused.
// STRUCTURE
//  mem_arb_pkg: state encodings (ARB_IDLE/ACCESS/WAIT/DONE), port ids (PORT_CPU=0, PORT_DMA=1),
//    MEM_LAT legality limit.
//  One sub-module: arb_lat_counter (4-bit loadable down-counter; load, dec, zero flag).
//  Winner select, FSM and latches stay in the top level.
// TESTING
//  1. MEM_LAT=1, CPU read 0x10, mem returns 0xDEADBEEF -> mem_en in cycle 1, cpu_ack and
//     cpu_rdata=0xDEADBEEF in cycle 2; cpu_stall high in cycles 0-1.
//  2. MEM_LAT=3, DMA write 0x20<=0x1234 -> one mem_en pulse with mem_we=1; dma_ack in cycle 4; CPU side idle.
//  3. Both req in the same cycle, repeated 4 times -> with ARB_RR_EN: grants CPU,DMA,CPU,DMA;
//     without it: CPU every time while CPU keeps requesting.
//  4. rst asserted during WAIT (MEM_LAT=5) -> immediately IDLE, no ack; all outputs at reset values.
//  5. CPU req raised while a DMA access is busy -> CPU is not granted until IDLE;
//     cpu_stall stays high throughout; CPU is granted next.
//  6. MEM_LAT=15 -> ack exactly 16 cycles after req is sampled; the counter does not wrap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   arb_state_t   FSM encodings (ARB_IDLE=00, ARB_ACCESS=01, ARB_WAIT=10, ARB_DONE=11)
//   PORT_CPU/DMA  requester ids as carried on grant_id
//   CNT_W         width of the latency counter
//   MEM_LAT_MIN/MAX legal memory latency range (limited by CNT_W)
//   arb_pick()    winner select for one arbitration decision
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_WAIT   = 2'b10,
    ARB_DONE   = 2'b11
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int CNT_W       = 4;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = (1 << CNT_W) - 1;

  // A lone requester always wins. On a tie, round-robin hands the grant to
  // the port that did not win last time; fixed priority favours the CPU.
  function automatic logic arb_pick(input logic cpu_req, input logic dma_req,
                                    input logic last_grant, input logic rr_en);
    logic win;
    if (cpu_req && dma_req) win = rr_en ? ~last_grant : PORT_CPU;
    else if (dma_req)       win = PORT_DMA;
    else                    win = PORT_CPU;
    return win;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: 4-bit loadable down-counter timing the memory latency.
//   clk, rst   clock, asynchronous active-high reset (count -> 0)
//   load       load load_val (has priority over dec)
//   load_val   value to load
//   dec        decrement by one; saturates at zero, never wraps
//   count      current value
//   zero       count == 0
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count <= '0;
    else if (load)         count <= load_val;
    else if (dec && !zero) count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between
// the CPU and a DMA/debug master.
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request and fields
//   cpu_ack, cpu_rdata       1-cycle completion pulse, read data (held between reads)
//   cpu_stall                cpu_req & ~cpu_ack
//   dma_*                    same set for the DMA port
//   mem_en/we/addr/wdata     memory strobe (1 cycle per access) and latched fields
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
//   busy, grant_id           FSM not idle; owner of the access in flight (0=CPU, 1=DMA)
//   state_dbg                FSM state for observation
// Macro ARB_RR_EN: defined -> round-robin on ties; undefined -> CPU wins ties.
//
// Handshake: a requester raises req with stable we/addr/wdata and holds them
// until it sees its ack; ack is a single-cycle pulse and the requester drops
// (or replaces) its request on that edge. Requests are only sampled in IDLE,
// so a request raised while busy simply waits; there is no timeout.
// Timing: req sampled in IDLE (cycle 0), mem_en in cycle 1, ack in MEM_LAT+1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic [1:0]    state_dbg
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

`ifdef ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t       state;
  logic             last_grant;
  logic [DW-1:0]    cpu_rdata_q;
  logic [DW-1:0]    dma_rdata_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             win;

  assign cnt_load = (state == ARB_ACCESS);
  assign cnt_dec  = (state == ARB_WAIT);
  assign win      = arb_pick(cpu_req, dma_req, last_grant, RR_EN);

  arb_lat_counter u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      grant_id    <= PORT_CPU;
      last_grant  <= PORT_DMA;
    end else begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (cpu_req || dma_req) begin
            grant_id  <= win;
            mem_we    <= (win == PORT_DMA) ? dma_we    : cpu_we;
            mem_addr  <= (win == PORT_DMA) ? dma_addr  : cpu_addr;
            mem_wdata <= (win == PORT_DMA) ? dma_wdata : cpu_wdata;
            mem_en    <= 1'b1;
            state     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          last_grant <= grant_id;
          if (MEM_LAT == 1) begin
            cpu_ack <= (grant_id == PORT_CPU);
            dma_ack <= (grant_id == PORT_DMA);
            state   <= ARB_DONE;
          end else begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // cnt_zero is only a safety exit: the FSM can never park in WAIT.
          if (cnt == CNT_W'(1) || cnt_zero) begin
            cpu_ack <= (grant_id == PORT_CPU);
            dma_ack <= (grant_id == PORT_DMA);
            state   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          if (!mem_we) begin
            if (grant_id == PORT_CPU) cpu_rdata_q <= mem_rdata;
            else                      dma_rdata_q <= mem_rdata;
          end
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory data is valid during DONE; pass it straight through with the ack
  // so rdata is valid in the ack cycle, then hold the captured copy.
  assign cpu_rdata = (cpu_ack && !mem_we) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (dma_ack && !mem_we) ? mem_rdata : dma_rdata_q;

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign dma_stall = dma_req & ~dma_ack;
  assign busy      = (state != ARB_IDLE);
  assign state_dbg = state;

endmodule
